xbus_net_arbiter: RTL and testbench

//  Schedules blocking XBus transfers on one shared XBus net joining NPORTS MC-series controllers.

---
 rtl/xbus_net_arbiter_pkg.sv | 20 ++
 rtl/xbus_net_arbiter_if.sv | 32 +++
 rtl/xbus_net_arbiter_rr_pick.sv | 38 +++
 rtl/xbus_net_arbiter.sv | 131 +++++++++++++
 tb/tb_xbus_net_arbiter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/xbus_net_arbiter_pkg.sv
// Shared definitions for the XBus net arbiter.
//   XBUS_DW  default data width of an XBus value (-999..999, two's complement)
//   state_t  arbiter FSM states
//   idx_w()  width of a port index for a given port count
package mc_xbus_pkg;

  localparam int XBUS_DW = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2,
    COOL  = 2'd3
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xbus_net_arbiter_if.sv
// XBus net signal bundle between the MC controllers and the arbiter.
//   master : controller side (drives wr_req/wr_dat/rd_req, sees acks and status)
//   slave  : arbiter side
//   wr_req/rd_req : per-port write/read requests
//   wr_dat        : packed per-port data, port i at [i*DW +: DW]
//   wr_ack/rd_ack : one-cycle ack pulses; rd_dat valid while rd_ack != 0
//   net_active, busy, xfer_cnt : status
interface xbus_net_arbiter_if #(
  parameter int NPORTS = 4,
  parameter int DW     = 11,
  parameter int CNTW   = 16
);
  logic [NPORTS-1:0]    wr_req;
  logic [NPORTS*DW-1:0] wr_dat;
  logic [NPORTS-1:0]    rd_req;
  logic [NPORTS-1:0]    wr_ack;
  logic [NPORTS-1:0]    rd_ack;
  logic [DW-1:0]        rd_dat;
  logic                 net_active;
  logic                 busy;
  logic [CNTW-1:0]      xfer_cnt;

  modport master (
    output wr_req, wr_dat, rd_req,
    input  wr_ack, rd_ack, rd_dat, net_active, busy, xfer_cnt
  );

  modport slave (
    input  wr_req, wr_dat, rd_req,
    output wr_ack, rd_ack, rd_dat, net_active, busy, xfer_cnt
  );
endinterface

// File: rtl/xbus_net_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   i_req   : request vector
//   i_start : index searched first; search wraps past NPORTS-1 to 0
//   i_excl  : mask of ports that may not be chosen
//   o_found : some non-excluded request exists
//   o_idx   : first such request at or after i_start
module rr_pick
  import mc_xbus_pkg::*;
#(
  parameter int NPORTS = 4,
  parameter int IW     = idx_w(NPORTS)
) (
  input  logic [NPORTS-1:0] i_req,
  input  logic [IW-1:0]     i_start,
  input  logic [NPORTS-1:0] i_excl,
  output logic              o_found,
  output logic [IW-1:0]     o_idx
);

  logic [NPORTS-1:0] w_cand;

  assign w_cand = i_req & ~i_excl;

  always_comb begin
    int unsigned j;
    j       = 0;
    o_found = 1'b0;
    o_idx   = '0;
    for (int unsigned k = 0; k < NPORTS; k++) begin
      j = (32'(i_start) + k) % NPORTS;
      if (!o_found && w_cand[IW'(j)]) begin
        o_found = 1'b1;
        o_idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/xbus_net_arbiter.sv
// Shared XBus net arbiter: pairs one pending writer with one pending reader
// (independent round-robin pointers), moves the writer's value to the reader
// and pulses both acks.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : xbus_net_arbiter_if slave modport (requests, data, acks, status)
module xbus_net_arbiter
  import mc_xbus_pkg::*;
#(
  parameter int NPORTS = 4,
  parameter int DW     = XBUS_DW,
  parameter int CNTW   = 16
) (
  input logic               clk,
  input logic               rst_n,
  xbus_net_arbiter_if.slave bus
);

  localparam int IW = idx_w(NPORTS);

  state_t              r_state, w_state_nxt;
  logic [IW-1:0]       r_wr_ptr, r_rd_ptr, r_w, r_r;
  logic [DW-1:0]       r_hold, r_rd_dat;
  logic [NPORTS-1:0]   r_wr_ack, r_rd_ack;
  logic [CNTW-1:0]     r_cnt;

  logic                w_wfound, w_rfound;
  logic [IW-1:0]       w_widx, w_ridx;
  logic [NPORTS-1:0]   w_rexcl;
  logic [DW-1:0]       w_wdat [NPORTS];
  logic                w_latch, w_fire;

  function automatic logic [NPORTS-1:0] onehot(input logic [IW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  for (genvar g = 0; g < NPORTS; g++) begin : g_dat
    assign w_wdat[g] = bus.wr_dat[g*DW +: DW];
  end

  rr_pick #(.NPORTS(NPORTS), .IW(IW)) u_wr_pick (
    .i_req   (bus.wr_req),
    .i_start (r_wr_ptr),
    .i_excl  ('0),
    .o_found (w_wfound),
    .o_idx   (w_widx)
  );

  // A port never reads its own write, so the chosen writer is masked out.
  assign w_rexcl = onehot(w_widx);

  rr_pick #(.NPORTS(NPORTS), .IW(IW)) u_rd_pick (
    .i_req   (bus.rd_req),
    .i_start (r_rd_ptr),
    .i_excl  (w_rexcl),
    .o_found (w_rfound),
    .o_idx   (w_ridx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_fire      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_wfound && w_rfound) begin
          w_latch     = 1'b1;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        // Either side withdrawing aborts silently; pointers stay put.
        if (bus.wr_req[r_w] && bus.rd_req[r_r]) begin
          w_fire      = 1'b1;
          w_state_nxt = ACK;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ACK:     w_state_nxt = COOL;
      COOL:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Acks, data, pointers and counter are loaded on the GRANT->ACK edge so
  // they are all visible together during the single ACK cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_w      <= '0;
      r_r      <= '0;
      r_hold   <= '0;
      r_wr_ack <= '0;
      r_rd_ack <= '0;
      r_rd_dat <= '0;
      r_cnt    <= '0;
    end else begin
      r_wr_ack <= '0;
      r_rd_ack <= '0;
      r_rd_dat <= '0;
      if (w_latch) begin
        r_w    <= w_widx;
        r_r    <= w_ridx;
        r_hold <= w_wdat[w_widx];
      end
      if (w_fire) begin
        r_wr_ack <= onehot(r_w);
        r_rd_ack <= onehot(r_r);
        r_rd_dat <= r_hold;
        r_wr_ptr <= (r_w == IW'(NPORTS-1)) ? '0 : r_w + 1'b1;
        r_rd_ptr <= (r_r == IW'(NPORTS-1)) ? '0 : r_r + 1'b1;
        if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.wr_ack     = r_wr_ack;
  assign bus.rd_ack     = r_rd_ack;
  assign bus.rd_dat     = r_rd_dat;
  assign bus.net_active = |bus.wr_req;
  assign bus.busy       = (r_state != IDLE);
  assign bus.xfer_cnt   = r_cnt;

endmodule

// File: tb/tb_xbus_net_arbiter.sv
// Bench for xbus_net_arbiter: transaction-level model predicts every transfer
// of an episode up front into a scoreboard; a monitor pops on each ack.
module tb_xbus_net_arbiter;
  localparam int NP = 4;
  localparam int DW = 11;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xbus_net_arbiter_if #(.NPORTS(NP), .DW(DW), .CNTW(CW)) bus ();

  xbus_net_arbiter #(.NPORTS(NP), .DW(DW), .CNTW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [NP-1:0] wa;
    logic [NP-1:0] ra;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   m_wp, m_rp, m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // First requesting port at or after start (wrapping), skipping excl.
  function automatic int pick(input logic [NP-1:0] req, input int start, input int excl);
    for (int k = 0; k < NP; k++) begin
      int j;
      j = (start + k) % NP;
      if (req[j] && j != excl) return j;
    end
    return -1;
  endfunction

  function automatic logic [NP*DW-1:0] rnd_dat();
    logic [NP*DW-1:0] v;
    for (int p = 0; p < NP; p++)
      v[p*DW +: DW] = DW'($urandom_range(0, 1998)) - DW'(999);
    return v;
  endfunction

  // Monitor: every ack must match the oldest prediction; idle data is zero.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("net_active", 32'(bus.net_active), 32'(|bus.wr_req));
        if (bus.wr_ack != '0 || bus.rd_ack != '0) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_ack actual=wr%b/rd%b required=none at %0t",
                     bus.wr_ack, bus.rd_ack, $time);
          end else begin
            e = sb.pop_front();
            chk("wr_ack", 32'(bus.wr_ack), 32'(e.wa));
            chk("rd_ack", 32'(bus.rd_ack), 32'(e.ra));
            chk("rd_dat", 32'(bus.rd_dat), 32'(e.d));
            chk("xfer_cnt", 32'(bus.xfer_cnt), 32'(e.c));
          end
        end else begin
          chk("rd_dat_idle", 32'(bus.rd_dat), 32'(0));
        end
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_wr_ack"}, 32'(bus.wr_ack), 32'(0));
    chk({tag, "_rd_ack"}, 32'(bus.rd_ack), 32'(0));
    chk({tag, "_rd_dat"}, 32'(bus.rd_dat), 32'(0));
    chk({tag, "_xfer_cnt"}, 32'(bus.xfer_cnt), 32'(0));
    chk({tag, "_busy"}, 32'(bus.busy), 32'(0));
  endtask

  task automatic model_reset();
    sb.delete();
    m_wp = 0;
    m_rp = 0;
    m_cnt = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.wr_req = '0;
    bus.rd_req = '0;
    bus.wr_dat = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Present a request set at once; ports hold until acked, then drop.
  task automatic run_episode(input logic [NP-1:0] wr, input logic [NP-1:0] rd,
                             input logic [NP*DW-1:0] dat);
    logic [NP-1:0] mw, mr;
    int w, r, n, seen, budget;
    exp_t e;
    mw = wr;
    mr = rd;
    n = 0;
    while (1) begin
      w = pick(mw, m_wp, -1);
      if (w < 0) break;
      r = pick(mr, m_rp, w);
      if (r < 0) break;
      if (m_cnt < (1 << CW) - 1) m_cnt++;
      e.wa = NP'(1 << w);
      e.ra = NP'(1 << r);
      e.d  = dat[w*DW +: DW];
      e.c  = CW'(m_cnt);
      sb.push_back(e);
      m_wp = (w + 1) % NP;
      m_rp = (r + 1) % NP;
      mw[w] = 1'b0;
      mr[r] = 1'b0;
      n++;
    end
    bus.wr_dat = dat;
    bus.wr_req = wr;
    bus.rd_req = rd;
    seen = 0;
    budget = 0;
    while (seen < n && budget < 8 * n + 10) begin
      @(posedge clk);
      #1;
      budget++;
      if (bus.wr_ack != '0 || bus.rd_ack != '0) begin
        seen++;
        bus.wr_req = bus.wr_req & ~bus.wr_ack;
        bus.rd_req = bus.rd_req & ~bus.rd_ack;
      end
    end
    chk("ack_count", 32'(seen), 32'(n));
    repeat (20) begin
      @(posedge clk);
      #1;
      if (n == 0) chk("stall_busy", 32'(bus.busy), 32'(0));
    end
    bus.wr_req = '0;
    bus.rd_req = '0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [NP*DW-1:0] d;
    logic got;
    bus.wr_req = '0;
    bus.rd_req = '0;
    bus.wr_dat = '0;

    // Reset values, then first transfer 0->1 carrying 42.
    do_reset();
    d = rnd_dat();
    d[0 +: DW] = 11'd42;
    run_episode(4'b0001, 4'b0010, d);

    // Fairness from reset: writers 0,2,0,2, count 1..4.
    do_reset();
    for (int i = 0; i < 4; i++) run_episode(4'b0101, 4'b1000, rnd_dat());

    // Self-exclusion stalls, then a second reader unblocks 2->3.
    run_episode(4'b0100, 4'b0100, rnd_dat());
    run_episode(4'b0100, 4'b1100, rnd_dat());

    // Withdrawal of the reader during GRANT.
    bus.wr_dat = rnd_dat();
    bus.wr_req = 4'b0010;
    bus.rd_req = 4'b1000;
    @(posedge clk);
    #1;
    chk("wd_grant_busy", 32'(bus.busy), 32'(1));
    bus.rd_req = 4'b0000;
    @(posedge clk);
    #1;
    chk("wd_abort_idle", 32'(bus.busy), 32'(0));
    repeat (6) @(posedge clk);
    #1;
    bus.wr_req = '0;
    run_episode(4'b0010, 4'b1000, rnd_dat());

    // Most negative value passes through unchanged, then rd_dat returns to 0.
    run_episode(4'b1001, 4'b0110, {NP{11'h419}});

    // Asynchronous reset while in ACK.
    bus.wr_dat = rnd_dat();
    bus.wr_req = 4'b0001;
    bus.rd_req = 4'b0010;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.wr_ack != '0) begin
        got = 1'b1;
        break;
      end
    end
    chk("rstack_seen", 32'(got), 32'(1));
    chk("rstack_wr_ack", 32'(bus.wr_ack), 32'(4'b0001));
    rst_n = 1'b0;
    #1;
    check_zero_outputs("rstack");
    bus.wr_req = '0;
    bus.rd_req = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_episode(4'b1111, 4'b1111, rnd_dat());

    // Randomized episodes.
    for (int i = 0; i < 40; i++)
      run_episode(NP'($urandom), NP'($urandom), rnd_dat());

    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
